// File: rtl/data_ram_responder.sv
// Big-endian, byte-addressable data memory responder with programmable access latency and busy/done handshake.
// Optional alignment checking is compiled in by defining DATA_RAM_ALIGN_CHECK_EN.
module data_ram_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RAM_Enable,
  input  logic                  RAM_RW,
  input  logic                  RAM_SE,
  input  logic [1:0]            RAM_Size,
  input  logic [ADDR_WIDTH-1:0] RAM_Address,
  input  logic [31:0]           RAM_DataIn,
  output logic [31:0]           RAM_DataOut,
  output logic                  RAM_Busy,
  output logic                  RAM_Done,
  output logic                  RAM_Misaligned
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic                  se_q, se_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           dout_q, dout_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mis_q, mis_d;

  logic [7:0]            mem [DEPTH];

  logic                  access;
  logic                  bad;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH-1:0] lane_addr [4];
  logic [7:0]            rd_byte [4];
  logic [7:0]            wr_byte [4];
  logic [3:0]            wr_en;
  logic [31:0]           load_val;

`ifdef DATA_RAM_ALIGN_CHECK_EN
  always_comb begin
    bad = 1'b0;
    case (size_q)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_q[0];
      2'b10:   bad = |addr_q[1:0];
      default: bad = 1'b1;
    endcase
  end

  assign base = addr_q;
`else
  assign bad = 1'b0;

  // Without checking, the address is silently aligned down; reserved size behaves as a word.
  always_comb begin
    base = addr_q;
    case (size_q)
      SZ_BYTE: base = addr_q;
      SZ_HALF: base = {addr_q[ADDR_WIDTH-1:1], 1'b0};
      default: base = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    endcase
  end
`endif

  always_comb begin
    nbytes = 3'd4;
    case (size_q)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // Lane 0 is the most significant byte of the transfer (big-endian); offsets wrap at the top of memory.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi] = base + ADDR_WIDTH'(gi);
      assign rd_byte[gi]   = mem[lane_addr[gi]];
      assign wr_en[gi]     = access && rw_q && !bad && (3'(gi) < nbytes);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_byte[i] = 8'h00;
    end
    case (size_q)
      SZ_BYTE: begin
        wr_byte[0] = wdata_q[7:0];
      end
      SZ_HALF: begin
        wr_byte[0] = wdata_q[15:8];
        wr_byte[1] = wdata_q[7:0];
      end
      default: begin
        wr_byte[0] = wdata_q[31:24];
        wr_byte[1] = wdata_q[23:16];
        wr_byte[2] = wdata_q[15:8];
        wr_byte[3] = wdata_q[7:0];
      end
    endcase
  end

  always_comb begin
    load_val = 32'h0;
    case (size_q)
      SZ_BYTE: load_val = {{24{se_q & rd_byte[0][7]}}, rd_byte[0]};
      SZ_HALF: load_val = {{16{se_q & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      default: load_val = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem[lane_addr[i]] <= wr_byte[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    se_d    = se_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (RAM_Enable) begin
          rw_d    = RAM_RW;
          se_d    = RAM_SE;
          size_d  = RAM_Size;
          addr_d  = RAM_Address;
          wdata_d = RAM_DataIn;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          done_d  = 1'b1;
          mis_d   = bad;
          state_d = DONE;
          if (!rw_q) begin
            dout_d = bad ? 32'h0 : load_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      dout_q  <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      se_q    <= se_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign RAM_DataOut    = dout_q;
  assign RAM_Busy       = busy_q;
  assign RAM_Done       = done_q;
  assign RAM_Misaligned = mis_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: one instance at LATENCY=1 and one at LATENCY=4, each checked
// against a byte-array reference model; alignment expectations follow DATA_RAM_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_data_ram_responder;

  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int LAT0  = 1;
  localparam int LAT1  = 4;

  typedef struct {
    int          cyc;
    logic [31:0] dout;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        en   [2];
  logic        rw   [2];
  logic        se   [2];
  logic [1:0]  size [2];
  logic [AW-1:0] addr [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        busy [2];
  logic        done [2];
  logic        mis  [2];

  data_ram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT0)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .RAM_Enable(en[0]), .RAM_RW(rw[0]), .RAM_SE(se[0]), .RAM_Size(size[0]),
    .RAM_Address(addr[0]), .RAM_DataIn(din[0]),
    .RAM_DataOut(dout[0]), .RAM_Busy(busy[0]), .RAM_Done(done[0]), .RAM_Misaligned(mis[0])
  );

  data_ram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT1)) u_lat4 (
    .clk(clk), .rst_n(rst_n),
    .RAM_Enable(en[1]), .RAM_RW(rw[1]), .RAM_SE(se[1]), .RAM_Size(size[1]),
    .RAM_Address(addr[1]), .RAM_DataIn(din[1]),
    .RAM_DataOut(dout[1]), .RAM_Busy(busy[1]), .RAM_Done(done[1]), .RAM_Misaligned(mis[1])
  );

  int checks = 0;
  int passed = 0;

  logic [7:0]  mem_m [2][DEPTH];
  logic [31:0] last_load [2];
  int          acc_k [2];
  exp_t        q0[$];
  exp_t        q1[$];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d cycle %0d: got 0x%08h, expected 0x%08h", name, d, cyc, act, exp);
  endtask

  // Reference: the memory is a plain byte array, the transfer is n bytes starting at the (possibly aligned) address,
  // most significant byte first; loads are sign-extended arithmetically.
  task automatic model(input int d, input logic rw_i, input logic se_i, input logic [1:0] sz, input int a_in,
                       input logic [31:0] data, output logic [31:0] e_dout, output logic e_mis);
    int     a;
    int     n;
    longint v;
    a = a_in;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e_mis = 1'b0;
`ifdef DATA_RAM_ALIGN_CHECK_EN
    if (sz == 2'd3 || (a % n) != 0) e_mis = 1'b1;
`else
    a = a - (a % n);
`endif
    if (rw_i) begin
      if (!e_mis)
        for (int i = 0; i < n; i++) mem_m[d][(a + i) % DEPTH] = 8'(data >> (8 * (n - 1 - i)));
    end else begin
      v = 0;
      if (!e_mis) begin
        for (int i = 0; i < n; i++) v = v * 256 + longint'(mem_m[d][(a + i) % DEPTH]);
        if (se_i && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      end
      last_load[d] = 32'(v);
    end
    e_dout = last_load[d];
  endtask

  // Called at a falling edge; returns at the falling edge just before the earliest next acceptance.
  task automatic issue(input int d, input logic rw_i, input logic se_i, input logic [1:0] sz, input int a,
                       input logic [31:0] data, input bit junk, input bit use_lit, input logic [31:0] lit,
                       input logic lit_mis);
    exp_t e;
    int   k;
    en[d] = 1'b1; rw[d] = rw_i; se[d] = se_i; size[d] = sz; addr[d] = AW'(a); din[d] = data;
    k = cyc + 1;
    model(d, rw_i, se_i, sz, a, data, e.dout, e.mis);
    if (use_lit) begin
      if (!rw_i) begin
        e.dout = lit;
        last_load[d] = lit;
      end
      e.mis = lit_mis;
    end
    e.cyc = k + lat_of(d);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    acc_k[d] = k;
    @(posedge clk);
    #1;
    en[d] = junk; rw[d] = 1'($urandom); se[d] = 1'($urandom); size[d] = 2'($urandom);
    addr[d] = AW'($urandom); din[d] = $urandom;
    while (cyc != k + lat_of(d) + 1) @(negedge clk);
    en[d] = 1'b0;
  endtask

  task automatic rand_ops(input int d, input int count, input bit allow_junk);
    for (int i = 0; i < count; i++) begin
      issue(d, 1'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, DEPTH - 1)), $urandom,
            allow_junk ? 1'($urandom) : 1'b0, 1'b0, 32'h0, 1'b0);
    end
  endtask

  exp_t mon_e;
  logic mon_eb;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mon_eb = (cyc >= acc_k[d]) && (cyc <= acc_k[d] + lat_of(d));
        chk("busy", d, 32'(busy[d]), 32'(mon_eb));
        if (done[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk("done_unexpected", d, 32'(done[d]), 32'd0);
          end else begin
            if (d == 0) mon_e = q0.pop_front();
            else mon_e = q1.pop_front();
            chk("done_cycle", d, 32'(cyc), 32'(mon_e.cyc));
            chk("misaligned", d, 32'(mis[d]), 32'(mon_e.mis));
            chk("data_out", d, dout[d], mon_e.dout);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; rw[d] = 1'b0; se[d] = 1'b0; size[d] = 2'b00; addr[d] = '0; din[d] = 32'h0;
      last_load[d] = 32'h0;
      acc_k[d] = -100;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", d, 32'(busy[d]), 32'd0);
      chk("reset_done", d, 32'(done[d]), 32'd0);
      chk("reset_mis", d, 32'(mis[d]), 32'd0);
      chk("reset_dout", d, dout[d], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a += 4) issue(d, 1'b1, 1'b0, 2'd2, a, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);

    // Directed sequence on the LATENCY=1 instance.
    issue(0, 1'b1, 1'b0, 2'd2, 'h010, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(0, 1'b0, 1'b0, 2'd2, 'h010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 1'b1, 2'd0, 'h013, 32'h0, 1'b0, 1'b1, 32'hFFFFFFEF, 1'b0);
    issue(0, 1'b0, 1'b0, 2'd0, 'h013, 32'h0, 1'b0, 1'b1, 32'h000000EF, 1'b0);
    issue(0, 1'b0, 1'b1, 2'd1, 'h010, 32'h0, 1'b0, 1'b1, 32'hFFFFDEAD, 1'b0);
    issue(0, 1'b1, 1'b0, 2'd0, 'h011, 32'h00000012, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(0, 1'b0, 1'b0, 2'd2, 'h010, 32'h0, 1'b0, 1'b1, 32'hDE12BEEF, 1'b0);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    issue(0, 1'b1, 1'b0, 2'd2, 'h012, 32'h11223344, 1'b0, 1'b1, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b0, 2'd2, 'h010, 32'h0, 1'b0, 1'b1, 32'hDE12BEEF, 1'b0);
    issue(0, 1'b0, 1'b0, 2'd1, 'h011, 32'h0, 1'b0, 1'b1, 32'h00000000, 1'b1);
    issue(0, 1'b0, 1'b0, 2'd2, 'h010, 32'h0, 1'b0, 1'b1, 32'hDE12BEEF, 1'b0);
    issue(0, 1'b0, 1'b1, 2'd3, 'h010, 32'h0, 1'b0, 1'b1, 32'h00000000, 1'b1);
`else
    issue(0, 1'b1, 1'b0, 2'd2, 'h012, 32'h11223344, 1'b0, 1'b1, 32'h0, 1'b0);
    issue(0, 1'b0, 1'b0, 2'd2, 'h010, 32'h0, 1'b0, 1'b1, 32'h11223344, 1'b0);
    issue(0, 1'b0, 1'b0, 2'd1, 'h011, 32'h0, 1'b0, 1'b1, 32'h00001122, 1'b0);
    issue(0, 1'b0, 1'b1, 2'd3, 'h013, 32'h0, 1'b0, 1'b1, 32'h11223344, 1'b0);
`endif
    rand_ops(0, 150, 1'b0);

    // LATENCY=4: requests while busy are ignored, and held enable gives back-to-back accesses.
    issue(1, 1'b1, 1'b0, 2'd2, 'h010, 32'hA5A55A5A, 1'b1, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b0, 1'b0, 2'd2, 'h010, 32'h0, 1'b1, 1'b1, 32'hA5A55A5A, 1'b0);
    issue(1, 1'b0, 1'b1, 2'd1, 'h012, 32'h0, 1'b1, 1'b1, 32'h00005A5A, 1'b0);
    issue(1, 1'b0, 1'b1, 2'd0, 'h010, 32'h0, 1'b1, 1'b1, 32'hFFFFFFA5, 1'b0);
    rand_ops(1, 100, 1'b1);

    // Reset in the middle of a LATENCY=4 store: no write and no completion.
    issue(1, 1'b1, 1'b0, 2'd2, 'h020, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b0, 1'b0, 2'd2, 'h010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    en[1] = 1'b1; rw[1] = 1'b1; se[1] = 1'b0; size[1] = 2'd2; addr[1] = AW'('h020); din[1] = 32'h0BADBEEF;
    k = cyc + 1;
    acc_k[1] = k;
    @(posedge clk);
    #1 en[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    acc_k[0] = -100;
    acc_k[1] = -100;
    last_load[0] = 32'h0;
    last_load[1] = 32'h0;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 1, 32'(busy[1]), 32'd0);
    chk("midreset_done", 1, 32'(done[1]), 32'd0);
    chk("midreset_mis", 1, 32'(mis[1]), 32'd0);
    chk("midreset_dout", 1, dout[1], 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 1'b0, 2'd2, 'h020, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    rand_ops(1, 40, 1'b1);

    repeat (10) @(negedge clk);
    chk("pending_done", 0, 32'(q0.size()), 32'd0);
    chk("pending_done", 1, 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
